// File: rtl/execution_unit.sv
//------------------------------------------------------------------------------
// execution_unit : read/execute/write sequencer wrapped around a register bank
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module execution_unit #(
   parameter int DATA_WIDTH = 32,
   parameter int SEL_WIDTH  = 6,
   parameter int REG_COUNT  = 28,
   parameter int NONE_SEL   = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [3:0]            opcode,
   input  logic [SEL_WIDTH-1:0]  src_a_sel,
   input  logic [SEL_WIDTH-1:0]  src_b_sel,
   input  logic [SEL_WIDTH-1:0]  dest_sel,
   input  logic [DATA_WIDTH-1:0] operand_a,
   input  logic [DATA_WIDTH-1:0] operand_b,
   output logic [SEL_WIDTH-1:0]  outa_sel,
   output logic [SEL_WIDTH-1:0]  outb_sel,
   output logic [SEL_WIDTH-1:0]  in_sel,
   output logic [DATA_WIDTH-1:0] in,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic                  zero,
   output logic                  carry
);

   localparam int                   CNT_W       = $clog2(DATA_WIDTH);
   localparam logic [SEL_WIDTH-1:0] c_NONE      = SEL_WIDTH'(NONE_SEL);
   localparam logic [SEL_WIDTH-1:0] c_REG_LIMIT = SEL_WIDTH'(REG_COUNT);
   localparam logic [CNT_W-1:0]     c_CNT_LAST  = CNT_W'(DATA_WIDTH - 1);

   localparam logic [3:0] c_OP_ADD  = 4'd0;
   localparam logic [3:0] c_OP_SUB  = 4'd1;
   localparam logic [3:0] c_OP_AND  = 4'd2;
   localparam logic [3:0] c_OP_OR   = 4'd3;
   localparam logic [3:0] c_OP_XOR  = 4'd4;
   localparam logic [3:0] c_OP_SHL  = 4'd5;
   localparam logic [3:0] c_OP_SHR  = 4'd6;
   localparam logic [3:0] c_OP_MUL  = 4'd7;
   localparam logic [3:0] c_OP_PASS = 4'd8;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_EXEC  = 2'd2,
      S_WRITE = 2'd3
   } state_t;

   state_t                r_state;
   logic [3:0]            r_opcode;
   logic [SEL_WIDTH-1:0]  r_dest;
   logic [DATA_WIDTH-1:0] r_a;
   logic [DATA_WIDTH-1:0] r_b;
   logic [DATA_WIDTH-1:0] r_acc;
   logic [CNT_W-1:0]      r_cnt;

   logic [DATA_WIDTH:0]   w_add;
   logic [DATA_WIDTH:0]   w_sub;
   logic [DATA_WIDTH-1:0] w_partial;
   logic [DATA_WIDTH-1:0] w_mul_acc;
   logic [DATA_WIDTH-1:0] w_result;
   logic                  w_carry;
   logic                  w_legal;
   logic                  w_exec_last;

   always_comb begin
      w_add     = {1'b0, r_a} + {1'b0, r_b};
      w_sub     = {1'b0, r_a} - {1'b0, r_b};
      // One multiplier bit per cycle, LSB first; the final add lands on the exit edge
      w_partial = r_b[r_cnt] ? (r_a << r_cnt) : '0;
      w_mul_acc = r_acc + w_partial;
      w_result  = r_a;
      w_carry   = 1'b0;
      case (r_opcode)
         c_OP_ADD: begin
            w_result = w_add[DATA_WIDTH-1:0];
            w_carry  = w_add[DATA_WIDTH];
         end
         c_OP_SUB: begin
            w_result = w_sub[DATA_WIDTH-1:0];
            w_carry  = w_sub[DATA_WIDTH];
         end
         c_OP_AND:  w_result = r_a & r_b;
         c_OP_OR:   w_result = r_a | r_b;
         c_OP_XOR:  w_result = r_a ^ r_b;
         c_OP_SHL:  w_result = r_a << r_b[CNT_W-1:0];
         c_OP_SHR:  w_result = r_a >> r_b[CNT_W-1:0];
         c_OP_MUL:  w_result = w_mul_acc;
         default:   w_result = r_a;
      endcase
      w_exec_last = (r_opcode != c_OP_MUL) || (r_cnt == c_CNT_LAST);
      w_legal     = (r_opcode <= c_OP_PASS) && (r_dest < c_REG_LIMIT);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_opcode <= '0;
         r_dest   <= c_NONE;
         r_a      <= '0;
         r_b      <= '0;
         r_acc    <= '0;
         r_cnt    <= '0;
         outa_sel <= c_NONE;
         outb_sel <= c_NONE;
         in_sel   <= c_NONE;
         in       <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         error    <= 1'b0;
         zero     <= 1'b0;
         carry    <= 1'b0;
      end else begin
         done  <= 1'b0;
         error <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_opcode <= opcode;
                  r_dest   <= dest_sel;
                  outa_sel <= src_a_sel;
                  outb_sel <= src_b_sel;
                  busy     <= 1'b1;
                  r_state  <= S_READ;
               end
            end
            S_READ: begin
               r_a      <= operand_a;
               r_b      <= operand_b;
               outa_sel <= c_NONE;
               outb_sel <= c_NONE;
               r_acc    <= '0;
               r_cnt    <= '0;
               // Illegal requests go straight to WRITE with the flags already raised
               if (!w_legal) begin
                  done    <= 1'b1;
                  error   <= 1'b1;
                  r_state <= S_WRITE;
               end else begin
                  r_state <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (r_opcode == c_OP_MUL) begin
                  r_acc <= w_mul_acc;
                  r_cnt <= r_cnt + 1'b1;
               end
               if (w_exec_last) begin
                  in_sel  <= r_dest;
                  in      <= w_result;
                  zero    <= (w_result == '0);
                  carry   <= w_carry;
                  done    <= 1'b1;
                  r_state <= S_WRITE;
               end
            end
            S_WRITE: begin
               in_sel  <= c_NONE;
               busy    <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_execution_unit.sv
//------------------------------------------------------------------------------
// tb_execution_unit : directed bench for execution_unit with a behavioural bank
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_execution_unit;

   localparam int RC = 28;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [3:0]  opcode;
   logic [5:0]  src_a_sel, src_b_sel, dest_sel;
   logic [31:0] operand_a, operand_b;
   logic [5:0]  outa_sel, outb_sel, in_sel;
   logic [31:0] in;
   logic        busy, done, error, zero, carry;

   int n_pass  = 0;
   int n_fail  = 0;
   int n_total = 0;
   int cyc     = 0;
   int t0      = 0;
   int lat     = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Combinational-read bank that commits on the edge after WRITE
   logic [31:0] bank [0:RC-1];
   logic        pl_en = 1'b0;
   logic [4:0]  pl_idx = '0;
   logic [31:0] pl_val = '0;

   always @(posedge clk) begin
      if (pl_en)
         bank[pl_idx] <= pl_val;
      else if (int'(in_sel) < RC)
         bank[in_sel[4:0]] <= in;
   end

   assign operand_a = (int'(outa_sel) < RC) ? bank[outa_sel[4:0]] : 32'h0;
   assign operand_b = (int'(outb_sel) < RC) ? bank[outb_sel[4:0]] : 32'h0;

   execution_unit dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .opcode    (opcode),
      .src_a_sel (src_a_sel),
      .src_b_sel (src_b_sel),
      .dest_sel  (dest_sel),
      .operand_a (operand_a),
      .operand_b (operand_b),
      .outa_sel  (outa_sel),
      .outb_sel  (outb_sel),
      .in_sel    (in_sel),
      .in        (in),
      .busy      (busy),
      .done      (done),
      .error     (error),
      .zero      (zero),
      .carry     (carry)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total = n_total + 1;
      assert (obs === exp) n_pass = n_pass + 1;
      else begin
         n_fail = n_fail + 1;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic preload(input int idx, input logic [31:0] val);
      @(negedge clk);
      pl_en  = 1'b1;
      pl_idx = 5'(idx);
      pl_val = val;
      @(negedge clk);
      pl_en  = 1'b0;
   endtask

   // Returns just after edge 0 (the edge that samples start)
   task automatic issue(input logic [3:0] op, input int a, input int b, input int d);
      @(negedge clk);
      start     = 1'b1;
      opcode    = op;
      src_a_sel = 6'(a);
      src_b_sel = 6'(b);
      dest_sel  = 6'(d);
      @(posedge clk);
      #1;
      t0    = cyc;
      start = 1'b0;
   endtask

   // Bounded wait; lat stays -1 on timeout so the latency check reports it
   task automatic wait_done();
      lat = -1;
      for (int k = 0; k < 60; k++) begin
         @(posedge clk);
         #1;
         if (done) begin
            lat = cyc - t0;
            break;
         end
      end
   endtask

   task automatic next_edge();
      @(posedge clk);
      #1;
   endtask

   logic [3:0]  lop  [4] = '{4'd2, 4'd3, 4'd4, 4'd8};
   logic [31:0] lexp [4] = '{32'h0000_0100, 32'h0001_2345, 32'h0001_2245, 32'h0001_2345};

   initial begin
      reset = 1'b1; start = 1'b0; opcode = '0;
      src_a_sel = '0; src_b_sel = '0; dest_sel = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_outa_sel", 32'(outa_sel), 32);
      check("rst_outb_sel", 32'(outb_sel), 32);
      check("rst_in_sel",   32'(in_sel),   32);
      check("rst_in",       in,            0);
      check("rst_flags",    {27'd0, busy, done, error, zero, carry}, 0);
      @(negedge clk);
      reset = 1'b0;

      preload(3, 32'd5);
      preload(4, 32'd7);
      preload(18, 32'h1818_1818);
      preload(14, 32'hDEAD_0014);
      preload(17, 32'h0000_1111);

      // ADD
      issue(4'd0, 3, 4, 10);
      check("add_outa_sel", 32'(outa_sel), 3);
      check("add_outb_sel", 32'(outb_sel), 4);
      check("add_busy", 32'(busy), 1);
      wait_done();
      check("add_latency", 32'(lat), 2);
      check("add_in_sel", 32'(in_sel), 10);
      check("add_in", in, 12);
      check("add_err_zero_carry", {29'd0, error, zero, carry}, 0);
      next_edge();
      check("add_r10", bank[10], 12);
      check("add_after_in_sel", 32'(in_sel), 32);
      check("add_after_done_busy", {30'd0, done, busy}, 0);

      // SUB with borrow
      issue(4'd1, 3, 4, 11);
      wait_done();
      check("sub_in", in, 32'hFFFF_FFFE);
      check("sub_carry", 32'(carry), 1);
      check("sub_zero", 32'(zero), 0);
      next_edge();
      check("sub_r11", bank[11], 32'hFFFF_FFFE);

      // Illegal opcode: flags and write data held
      issue(4'd12, 3, 4, 18);
      wait_done();
      check("illop_latency", 32'(lat), 1);
      check("illop_done_error", {30'd0, done, error}, 3);
      check("illop_in_sel", 32'(in_sel), 32);
      check("illop_in_held", in, 32'hFFFF_FFFE);
      check("illop_carry_held", 32'(carry), 1);
      next_edge();
      check("illop_r18", bank[18], 32'h1818_1818);
      check("illop_after", {29'd0, done, error, busy}, 0);

      // SUB to zero
      issue(4'd1, 4, 4, 12);
      wait_done();
      check("subz_in", in, 0);
      check("subz_zero_carry", {30'd0, zero, carry}, 2);
      next_edge();
      check("subz_r12", bank[12], 0);

      // Illegal destination
      issue(4'd0, 3, 4, 30);
      wait_done();
      check("illdst_done_error", {30'd0, done, error}, 3);
      check("illdst_in_sel", 32'(in_sel), 32);
      check("illdst_zero_carry", {30'd0, zero, carry}, 2);
      next_edge();

      // Logic ops and PASS
      preload(5, 32'h0001_2345);
      preload(6, 32'h0000_0100);
      for (int i = 0; i < 4; i++) begin
         issue(lop[i], 5, 6, 20 + i);
         wait_done();
         check($sformatf("logic_op%0d_in", lop[i]), in, lexp[i]);
         next_edge();
         check($sformatf("logic_op%0d_reg", lop[i]), bank[20 + i], lexp[i]);
      end

      // MUL with an ignored start pulse mid-operation
      issue(4'd7, 5, 6, 13);
      repeat (5) @(posedge clk);
      @(negedge clk);
      start = 1'b1; opcode = 4'd0; src_a_sel = 6'd3; src_b_sel = 6'd4; dest_sel = 6'd14;
      @(posedge clk);
      #1;
      start = 1'b0;
      check("mul_busy_mid", 32'(busy), 1);
      wait_done();
      check("mul_latency", 32'(lat), 33);
      check("mul_in", in, 32'h0123_4500);
      check("mul_in_sel", 32'(in_sel), 13);
      check("mul_carry", 32'(carry), 0);
      next_edge();
      check("mul_r13", bank[13], 32'h0123_4500);
      repeat (4) next_edge();
      check("mul_no_queue_busy", 32'(busy), 0);
      check("mul_no_queue_r14", bank[14], 32'hDEAD_0014);

      // Shifts, including upper bits of b ignored
      preload(1, 32'h8000_0001);
      preload(2, 32'd4);
      issue(4'd5, 1, 2, 15);
      wait_done();
      check("shl_in", in, 32'h0000_0010);
      next_edge();
      check("shl_r15", bank[15], 32'h0000_0010);
      issue(4'd6, 1, 2, 16);
      wait_done();
      check("shr_in", in, 32'h0800_0000);
      next_edge();
      preload(2, 32'hFFFF_FFE4);
      issue(4'd5, 1, 2, 15);
      wait_done();
      check("shl_hi_in", in, 32'h0000_0010);
      next_edge();
      issue(4'd6, 1, 2, 16);
      wait_done();
      check("shr_hi_in", in, 32'h0800_0000);
      next_edge();
      check("shr_r16", bank[16], 32'h0800_0000);

      // Reset during EXEC cycle 10 of a MUL
      issue(4'd7, 5, 6, 17);
      repeat (11) @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      check("rstmul_sels", {14'd0, outa_sel, outb_sel, in_sel}, {14'd0, 6'd32, 6'd32, 6'd32});
      check("rstmul_busy_done", {30'd0, busy, done}, 0);
      @(negedge clk);
      reset = 1'b0;
      repeat (40) next_edge();
      check("rstmul_r17", bank[17], 32'h0000_1111);
      check("rstmul_idle", {31'd0, busy}, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire
